// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data memory, sized loads and stores, and branch resolution.
// Optional build macro MISALIGN_TRAP_EN adds a Misaligned flag and blocks misaligned accesses.
module memory_stage #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] AddResult,
    input  logic        Zero,
    input  logic        SignBit,
    input  logic [31:0] ALUResult,
    input  logic [31:0] Rt,
    input  logic [4:0]  AddressSelected,
    input  logic [2:0]  BranchLogicOp,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemToReg,
    input  logic        RegWrite,
    input  logic [1:0]  BitSel,
    output logic [31:0] MemoryRead_out,
    output logic [31:0] ALUResult_out,
    output logic [4:0]  AddressSelected_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic        PCSrc
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        Misaligned
`endif
);

    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_BYTE = 2'b10;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wordIdx;
    logic [1:0]        byteOff;
    logic              isHalf;
    logic              isByte;
    logic              misalign;
    logic [31:0]       curWord;
    logic [31:0]       storeWord;
    logic [31:0]       loadWord;
    logic [7:0]        selByte;
    logic [15:0]       selHalf;
    logic              branchCond;

    // The branch target is muxed in IF; high address bits wrap away.
    logic unusedBits;
    assign unusedBits = ^{AddResult, ALUResult[31:ADDR_W+2]};

    assign wordIdx = ALUResult[ADDR_W+1:2];
    assign byteOff = ALUResult[1:0];
    assign isHalf  = (BitSel == SEL_HALF);
    assign isByte  = (BitSel == SEL_BYTE);
    assign curWord = mem[wordIdx];

`ifdef MISALIGN_TRAP_EN
    assign misalign = Rst && (MemRead || MemWrite) &&
                      ((!isHalf && !isByte && byteOff != 2'b00) || (isHalf && byteOff[0]));
    assign Misaligned = misalign;
`else
    assign misalign = 1'b0;
`endif

    // Merge store data into the current word so unselected lanes keep their contents.
    always_comb begin
        storeWord = curWord;
        selByte   = curWord[{byteOff, 3'b000} +: 8];
        selHalf   = byteOff[1] ? curWord[31:16] : curWord[15:0];
        if (isByte) begin
            storeWord[{byteOff, 3'b000} +: 8] = Rt[7:0];
        end else if (isHalf) begin
            if (byteOff[1]) storeWord[31:16] = Rt[15:0];
            else            storeWord[15:0]  = Rt[15:0];
        end else begin
            storeWord = Rt;
        end
    end

    always_comb begin
        loadWord = 32'd0;
        if (Rst && MemRead && !misalign) begin
            if (isByte)      loadWord = {{24{selByte[7]}}, selByte};
            else if (isHalf) loadWord = {{16{selHalf[15]}}, selHalf};
            else             loadWord = curWord;
        end
    end

    always_comb begin
        branchCond = 1'b0;
        case (BranchLogicOp)
            3'b000:  branchCond = Zero;
            3'b001:  branchCond = !Zero;
            3'b010:  branchCond = !SignBit;
            3'b011:  branchCond = !SignBit && !Zero;
            3'b100:  branchCond = SignBit || Zero;
            3'b101:  branchCond = SignBit;
            3'b110:  branchCond = 1'b1;
            default: branchCond = 1'b0;
        endcase
    end

    // Reads see the pre-edge contents; a same-cycle store lands on this edge.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
        end else if (MemWrite && !misalign) begin
            mem[wordIdx] <= storeWord;
        end
    end

    assign MemoryRead_out      = loadWord;
    assign ALUResult_out       = ALUResult;
    assign AddressSelected_out = AddressSelected;
    assign RegWrite_out        = Rst && RegWrite;
    assign MemToReg_out        = Rst && MemToReg;
    assign PCSrc               = Rst && Branch && branchCond;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage against a byte-addressed reference memory and a branch truth table.
// Honors MISALIGN_TRAP_EN when the build defines it.
module tb_memory_stage;

    localparam int DEPTH = 1024;
    localparam int BYTES = 4 * DEPTH;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] AddResult;
    logic        Zero;
    logic        SignBit;
    logic [31:0] ALUResult;
    logic [31:0] Rt;
    logic [4:0]  AddressSelected;
    logic [2:0]  BranchLogicOp;
    logic        Branch;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
    logic        RegWrite;
    logic [1:0]  BitSel;
    logic [31:0] MemoryRead_out;
    logic [31:0] ALUResult_out;
    logic [4:0]  AddressSelected_out;
    logic        RegWrite_out;
    logic        MemToReg_out;
    logic        PCSrc;
`ifdef MISALIGN_TRAP_EN
    logic        Misaligned;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0]  refBytes [BYTES];
    logic [31:0] expQ [$];

    memory_stage #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
        .Clk(Clk), .Rst(Rst), .AddResult(AddResult), .Zero(Zero), .SignBit(SignBit),
        .ALUResult(ALUResult), .Rt(Rt), .AddressSelected(AddressSelected),
        .BranchLogicOp(BranchLogicOp), .Branch(Branch), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWrite(RegWrite), .BitSel(BitSel),
        .MemoryRead_out(MemoryRead_out), .ALUResult_out(ALUResult_out),
        .AddressSelected_out(AddressSelected_out), .RegWrite_out(RegWrite_out),
        .MemToReg_out(MemToReg_out), .PCSrc(PCSrc)
`ifdef MISALIGN_TRAP_EN
        , .Misaligned(Misaligned)
`endif
    );

    // Clock
    always #5 Clk = ~Clk;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: plain byte array, addresses wrap at the memory size.
    function automatic int accessBytes(input logic [1:0] sel);
        if (sel == 2'b01) return 2;
        if (sel == 2'b10) return 1;
        return 4;
    endfunction

    function automatic int baseAddr(input logic [31:0] addr, input logic [1:0] sel);
        int n = accessBytes(sel);
        int unsigned a = addr % BYTES;
        return int'(a / n * n);
    endfunction

    function automatic bit refMisaligned(input logic [31:0] addr, input logic [1:0] sel,
                                         input bit rd, input bit wr);
`ifdef MISALIGN_TRAP_EN
        if (!(rd || wr)) return 1'b0;
        return (addr % accessBytes(sel)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelStore(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sel);
        int n = accessBytes(sel);
        int b = baseAddr(addr, sel);
        for (int i = 0; i < n; i++) refBytes[b + i] = data[8*i +: 8];
    endtask

    function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [1:0] sel);
        int n = accessBytes(sel);
        int b = baseAddr(addr, sel);
        logic [31:0] v = 32'd0;
        if (refMisaligned(addr, sel, 1'b1, 1'b0)) return 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = refBytes[b + i];
        if (n == 1) v = {{24{v[7]}}, v[7:0]};
        if (n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    function automatic logic refBranch(input logic br, input logic [2:0] op, input logic z, input logic s);
        logic cond;
        case (op)
            3'd0: cond = z;
            3'd1: cond = !z;
            3'd2: cond = !s;
            3'd3: cond = !s && !z;
            3'd4: cond = s || z;
            3'd5: cond = s;
            3'd6: cond = 1'b1;
            default: cond = 1'b0;
        endcase
        return br && cond;
    endfunction

    // Drivers
    task automatic doStore(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sel);
        bit mis = refMisaligned(addr, sel, 1'b0, 1'b1);
        @(negedge Clk);
        ALUResult = addr; Rt = data; BitSel = sel; MemWrite = 1'b1; MemRead = 1'b0;
        #1;
`ifdef MISALIGN_TRAP_EN
        checkValue("store_misaligned", {31'd0, Misaligned}, {31'd0, mis});
`endif
        @(posedge Clk);
        #1;
        if (!mis) modelStore(addr, data, sel);
        MemWrite = 1'b0;
    endtask

    task automatic doLoad(input logic [31:0] addr, input logic [1:0] sel, input string tag,
                          output logic [31:0] got);
        @(negedge Clk);
        ALUResult = addr; BitSel = sel; MemRead = 1'b1; MemWrite = 1'b0;
        #1;
        expQ.push_back(modelLoad(addr, sel));
        got = MemoryRead_out;
        checkValue(tag, got, expQ.pop_front());
`ifdef MISALIGN_TRAP_EN
        checkValue("load_misaligned", {31'd0, Misaligned}, {31'd0, refMisaligned(addr, sel, 1'b1, 1'b0)});
`endif
        MemRead = 1'b0;
    endtask

    task automatic doReadWrite(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sel);
        @(negedge Clk);
        ALUResult = addr; Rt = data; BitSel = sel; MemRead = 1'b1; MemWrite = 1'b1;
        #1;
        expQ.push_back(modelLoad(addr, sel));
        checkValue("rw_old_data", MemoryRead_out, expQ.pop_front());
        @(posedge Clk);
        #1;
        if (!refMisaligned(addr, sel, 1'b1, 1'b1)) modelStore(addr, data, sel);
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic doBranch(input logic br, input logic [2:0] op, input logic z, input logic s,
                            input string tag, output logic got);
        @(negedge Clk);
        Branch = br; BranchLogicOp = op; Zero = z; SignBit = s;
        #1;
        got = PCSrc;
        checkValue(tag, {31'd0, got}, {31'd0, refBranch(br, op, z, s)});
        Branch = 1'b0;
    endtask

    task automatic doCtrl(input logic [31:0] addr, input logic [4:0] rd, input logic rw, input logic m2r);
        @(negedge Clk);
        ALUResult = addr; AddressSelected = rd; RegWrite = rw; MemToReg = m2r;
        MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        checkValue("pass_alu", ALUResult_out, addr);
        checkValue("pass_rd", {27'd0, AddressSelected_out}, {27'd0, rd});
        checkValue("pass_regwrite", {31'd0, RegWrite_out}, {31'd0, rw});
        checkValue("pass_memtoreg", {31'd0, MemToReg_out}, {31'd0, m2r});
        checkValue("pass_noread", MemoryRead_out, 32'd0);
    endtask

    logic [31:0] got;
    logic        pc;

    initial begin
        for (int i = 0; i < BYTES; i++) refBytes[i] = 8'd0;

        // Reset with a store, a load, a taken branch and WB enables all asserted.
        Rst = 1'b0; AddResult = 32'h0000_1000; Zero = 1'b1; SignBit = 1'b0;
        ALUResult = 32'h40; Rt = 32'hCAFE_F00D; AddressSelected = 5'd9;
        BranchLogicOp = 3'b110; Branch = 1'b1; MemRead = 1'b1; MemWrite = 1'b1;
        MemToReg = 1'b1; RegWrite = 1'b1; BitSel = 2'b00;
        @(posedge Clk);
        #1;
        checkValue("rst_read", MemoryRead_out, 32'd0);
        checkValue("rst_pcsrc", {31'd0, PCSrc}, 32'd0);
        checkValue("rst_regwrite", {31'd0, RegWrite_out}, 32'd0);
        checkValue("rst_memtoreg", {31'd0, MemToReg_out}, 32'd0);
        checkValue("rst_pass_alu", ALUResult_out, 32'h40);
        checkValue("rst_pass_rd", {27'd0, AddressSelected_out}, 32'd9);
        @(negedge Clk);
        Rst = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; Branch = 1'b0; RegWrite = 1'b0; MemToReg = 1'b0;
        doLoad(32'h40, 2'b00, "rst_store_blocked", got);
        checkValue("rst_store_blocked_const", got, 32'd0);

        // Sized stores and loads.
        doStore(32'h10, 32'hDEAD_BEEF, 2'b00);
        doLoad(32'h10, 2'b00, "lw_10", got);  checkValue("lw_10_const", got, 32'hDEAD_BEEF);
        doLoad(32'h13, 2'b10, "lb_13", got);  checkValue("lb_13_const", got, 32'hFFFF_FFDE);
        doLoad(32'h10, 2'b01, "lh_10", got);  checkValue("lh_10_const", got, 32'hFFFF_BEEF);
        doStore(32'h11, 32'h0000_0012, 2'b10);
        doLoad(32'h10, 2'b00, "lw_after_sb", got); checkValue("lw_after_sb_const", got, 32'hDEAD_12EF);
        doStore(32'h12, 32'h0000_7654, 2'b01);
        doLoad(32'h10, 2'b00, "lw_after_sh", got); checkValue("lw_after_sh_const", got, 32'h7654_12EF);
        doLoad(32'h12, 2'b01, "lh_12", got);  checkValue("lh_12_const", got, 32'h0000_7654);
        doLoad(32'h10, 2'b11, "lw_sel11", got); checkValue("lw_sel11_const", got, 32'h7654_12EF);
        doLoad(32'h10 + BYTES, 2'b00, "lw_wrap", got); checkValue("lw_wrap_const", got, 32'h7654_12EF);

        // Same-cycle read and write returns the old word.
        doReadWrite(32'h10, 32'h0BAD_CAFE, 2'b00);
        doLoad(32'h10, 2'b00, "lw_after_rw", got); checkValue("lw_after_rw_const", got, 32'h0BAD_CAFE);

        // Word store to an unaligned address.
        doStore(32'h20, 32'h1111_1111, 2'b00);
        doStore(32'h22, 32'h9999_9999, 2'b00);
        doLoad(32'h20, 2'b00, "lw_unaligned_store", got);
`ifdef MISALIGN_TRAP_EN
        checkValue("lw_unaligned_store_const", got, 32'h1111_1111);
`else
        checkValue("lw_unaligned_store_const", got, 32'h9999_9999);
`endif

        // Branch table.
        doBranch(1'b1, 3'b000, 1'b1, 1'b0, "beq_taken", pc);   checkValue("beq_const", {31'd0, pc}, 32'd1);
        doBranch(1'b1, 3'b001, 1'b1, 1'b0, "bne_not", pc);     checkValue("bne_const", {31'd0, pc}, 32'd0);
        doBranch(1'b1, 3'b011, 1'b0, 1'b0, "bgtz_taken", pc);  checkValue("bgtz_const", {31'd0, pc}, 32'd1);
        doBranch(1'b1, 3'b100, 1'b0, 1'b1, "blez_taken", pc);  checkValue("blez_const", {31'd0, pc}, 32'd1);
        doBranch(1'b1, 3'b110, 1'b0, 1'b0, "jump_taken", pc);  checkValue("jump_const", {31'd0, pc}, 32'd1);
        doBranch(1'b1, 3'b111, 1'b1, 1'b1, "op7_never", pc);   checkValue("op7_const", {31'd0, pc}, 32'd0);
        doBranch(1'b0, 3'b110, 1'b1, 1'b0, "nobranch", pc);    checkValue("nobranch_const", {31'd0, pc}, 32'd0);

        doCtrl(32'h1234, 5'd17, 1'b1, 1'b1);

        // Randomized traffic over a small window so accesses collide, with occasional wrap bits.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] addr;
            logic [1:0]  sel;
            addr = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFF_F000);
            sel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0, 1: doStore(addr, $urandom, sel);
                2:    doLoad(addr, sel, "rand_load", got);
                3:    doReadWrite(addr, $urandom, sel);
                default: begin
                    doBranch(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_branch", pc);
                    doCtrl($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));
                end
            endcase
        end

        // Second reset clears everything written above.
        @(negedge Clk);
        Rst = 1'b0; MemWrite = 1'b1; ALUResult = 32'h44; Rt = $urandom; BitSel = 2'b00;
        @(posedge Clk);
        #1;
        Rst = 1'b1; MemWrite = 1'b0;
        for (int i = 0; i < BYTES; i++) refBytes[i] = 8'd0;
        for (int a = 0; a < 256; a += 4) doLoad(a, 2'b00, "cleared", got);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline.
- Holds the data memory and performs word, halfword and byte loads and stores.
- Evaluates the branch condition to produce PCSrc for the fetch stage.
- Passes writeback controls and data toward the external MEM/WB register; this block contains no pipeline register itself.

Parameters:
- DEPTH, 1024, number of 32-bit data-memory words.
- ADDR_W, 10, word-index width; must equal log2(DEPTH).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous reset, active-low.
- AddResult  in  32  branch target from EX. Accepted but not consumed here; target muxing happens in IF.
- Zero  in  1  ALU zero flag.
- SignBit  in  1  ALU result sign bit.
- ALUResult  in  32  byte address for memory ops, and pass-through data.
- Rt  in  32  store data.
- AddressSelected  in  5  destination register number.
- BranchLogicOp  in  3  branch condition select.
- Branch  in  1  instruction is a branch.
- MemRead  in  1  load enable.
- MemWrite  in  1  store enable.
- MemToReg  in  1  WB mux select, passed through.
- RegWrite  in  1  WB write enable, passed through.
- BitSel  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
- MemoryRead_out  out  32  load data.
- ALUResult_out  out  32  equals ALUResult.
- AddressSelected_out  out  5  equals AddressSelected.
- RegWrite_out  out  1  equals RegWrite.
- MemToReg_out  out  1  equals MemToReg.
- PCSrc  out  1  branch taken.

Behaviour:
- Reset (Rst=0 sampled at a rising Clk edge):
  - All DEPTH words are cleared to 0.
  - Any store in that cycle is suppressed.
- Outputs while Rst=0 (combinational): PCSrc=0, RegWrite_out=0, MemToReg_out=0, MemoryRead_out=0.
- ALUResult_out and AddressSelected_out always pass through, including during reset.
- Addressing:
  - Word index = ALUResult[ADDR_W+1:2]; byte offset = ALUResult[1:0].
  - Higher address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
  - Lanes are little-endian: offset 0 = bits 7:0.
- Stores happen on the rising Clk edge when Rst=1 and MemWrite=1:
  - Word: writes Rt to the whole word.
  - Halfword: writes Rt[15:0] to bits 15:0 if ALUResult[1]=0, else to bits 31:16.
  - Byte: writes Rt[7:0] to the lane selected by offset.
  - Unselected lanes are preserved.
- Loads are combinational (zero latency):
  - MemRead=1, word: the full word.
  - MemRead=1, halfword: the addressed halfword, sign-extended.
  - MemRead=1, byte: the addressed byte, sign-extended.
  - MemRead=0: MemoryRead_out=0.
- Same-cycle read and write to the same word: the read returns the old contents; the new value is visible after the edge.
- Alignment: word accesses ignore offset bits 1:0; halfword accesses ignore bit 0.
- PCSrc = Branch AND cond, where cond by BranchLogicOp:
  - 000 beq: Zero
  - 001 bne: !Zero
  - 010 bgez: !SignBit
  - 011 bgtz: !SignBit & !Zero
  - 100 blez: SignBit | Zero
  - 101 bltz: SignBit
  - 110 unconditional: 1
  - 111: 0
- Branch=0 forces PCSrc=0 regardless of op.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- When defined:
  - Adds output Misaligned (1 bit), combinational.
  - Misaligned=1 when (MemRead|MemWrite) and either a word access has ALUResult[1:0]!=0 or a halfword access has ALUResult[0]=1.
  - A misaligned store is suppressed.
  - A misaligned load returns 0.
  - Misaligned=0 while Rst=0.
- When undefined: no extra port; misaligned accesses use the truncation rules above.

Test Plan:
- Hold Rst=0 for one edge, then read address 0x40 with MemRead=1, BitSel=00 -> MemoryRead_out=0; PCSrc=0 and RegWrite_out=0 during reset.
- Store word Rt=0xDEADBEEF at 0x10, then load word -> 0xDEADBEEF. Load byte at 0x13 -> 0xFFFFFFDE. Load half at 0x10 -> 0xFFFFBEEF.
- After the previous step, store byte Rt=0x12 at 0x11, then load word at 0x10 -> 0xDEAD12EF. Store half Rt=0x7654 at 0x12 -> word reads 0x765412EF; load half at 0x12 -> 0x00007654.
- Branch=1: op 000 with Zero=1 -> PCSrc=1; op 001 with Zero=1 -> 0; op 011 with SignBit=0, Zero=0 -> 1; op 100 with SignBit=1 -> 1; op 110 -> 1; op 111 -> 0. Branch=0 with op 110 -> 0.
- With Rst=1: ALUResult=0x1234, AddressSelected=5'd17, RegWrite=1, MemToReg=1, MemRead=0 -> outputs 0x1234, 17, 1, 1, and MemoryRead_out=0.
- With MISALIGN_TRAP_EN: store word to 0x22 -> Misaligned=1 and memory unchanged; a later word load at 0x20 returns the prior value.
